cnt_seq_monitor: RTL and testbench
==================================

Name: cnt_seq_monitor

Overview:
- Observes the output of a bounded up/down counter (value range MIN..MAX, wrap at the bounds) one sample per cycle.
- Checks that the observed sequence is legal and reports:
  - inferred count direction;
  - wrap events and a lap count;
  - holds (stop), direction reversals and illegal steps.
- Sits on the consumer side of counter-driven logic as a run-time checker and status source.

Parameters:
- W, 4, width of the observed count and of the bounds.
- ERRW, 8, width of the saturating error counter and of the lap counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  sample enable; cnt_in is valid on cycles where en=1.
- cnt_in  in  W  observed count value.
- min  in  W  lower bound, quasi-static.
- max  in  W  upper bound, quasi-static.
- clr_err  in  1  synchronous clear of err_cnt and lap_cnt.
- locked  out  1  direction established and tracking.
- dir_up  out  1  1=up, 0=down; meaningful only while locked=1.
- hold  out  1  last sample equal to the previous sample.
- wrap_pulse  out  1  one-cycle pulse, legal wrap seen.
- flip_pulse  out  1  one-cycle pulse, direction reversal seen.
- step_err  out  1  one-cycle pulse, illegal step or out-of-range value.
- cfg_err  out  1  level, asserted while min>max.
- err_cnt  out  ERRW  count of step_err events, saturating.
- lap_cnt  out  ERRW  count of wrap_pulse events, wraps modulo 2^ERRW.

Behaviour:
- All outputs are registered. Response appears on the cycle after the sample edge, i.e. 1-cycle latency.
- Reset (rst=1 at a rising edge):
  - state=IDLE, prev=0.
  - All outputs 0; dir_up=1.
  - Reset mid-sequence discards prev and all status.
- States: IDLE (no previous sample), ACQ (previous sample held, direction unknown), TRACK (direction known).
- Sample classification, evaluated when en=1 in ACQ/TRACK, current sample c against previous sample p. Priority order:
  1. OOR: c<min or c>max.
  2. HOLD: c==p.
  3. UPW: p==max and c==min.
  4. DNW: p==min and c==max.
  5. UP: c==p+1 and p!=max.
  6. DN: c==p-1 and p!=min.
  7. else ILL.
- Arithmetic: p+1 and p-1 are evaluated in W+1 bits, so no modulo aliasing; e.g. p=15, c=0 is not UP.
- Degenerate range min==max: every in-range sample is HOLD.
- IDLE transitions:
  - en=1 and c in range and cfg_err=0 → capture p=c, go to ACQ.
  - Out-of-range first sample → step_err, stay in IDLE.
- ACQ transitions:
  - HOLD → hold=1, stay.
  - UP/UPW → dir_up=1, locked=1, go to TRACK.
  - DN/DNW → dir_up=0, locked=1, go to TRACK.
  - UPW/DNW also pulse wrap_pulse and increment lap_cnt.
  - OOR/ILL → step_err, go to IDLE if OOR, otherwise stay in ACQ with p=c.
- TRACK transitions:
  - Step in the current direction → no flags, except wrap_pulse on UPW/DNW.
  - Step in the opposite direction → flip_pulse, dir_up updated, stay locked. An opposite-direction wrap also gives wrap_pulse.
  - HOLD → hold=1, stay locked.
  - OOR/ILL → step_err, locked=0; go to ACQ with p=c, or to IDLE if OOR.
- p updates to c on every accepted sample, except in IDLE on OOR.
- en=0 at a rising edge:
  - State → IDLE, locked=0, hold=0, p invalidated.
  - No pulses.
  - err_cnt and lap_cnt retained.
- cfg_err:
  - Registered each cycle from min>max.
  - While asserted, the FSM is forced to IDLE and no classification occurs.
- Counters:
  - err_cnt increments on each step_err and saturates at all-ones.
  - lap_cnt wraps.
  - clr_err zeroes both. If clr_err coincides with an event, the clear wins and the counter goes to 0.
- hold is a level that reflects the most recent classification.

Test Plan:
- W=4, min=3, max=9, en=1. Feed 3,4,…,9,3,4.
  - locked=1 and dir_up=1 from the cycle after sample 4.
  - wrap_pulse exactly once, the cycle after the second 3.
  - lap_cnt=1; step_err never asserted.
- Down sequence 9,8,…,3,9 with min=3, max=9 → dir_up=0, one wrap_pulse after the final 9, lap_cnt=1.
- Fault and range cases:
  - Sequence 5,6,8 → step_err pulse after 8, locked=0, err_cnt=1.
  - Then 9 → re-lock up with no error.
  - Sample 12 (OOR) → step_err, FSM back to IDLE.
- Reversal and hold:
  - Sequence 4,5,6,5,4 → flip_pulse once after the second 5, dir_up=0, locked stays 1.
  - 6,6,6 → hold=1 while locked.
- Configuration and saturation:
  - min=10, max=2 → cfg_err=1, no pulses for any cnt_in.
  - Restore min=0, max=15 → normal operation; 15,0 → wrap_pulse.
  - Drive 260 illegal steps → err_cnt saturates at 255.
- Control:
  - Assert rst mid-tracking → all outputs 0, dir_up=1 next cycle.
  - Drop en for 3 cycles → locked=0, counters retained.
  - Pulse clr_err together with a step_err → err_cnt=0.

Source files
------------

// File: rtl/cnt_seq_monitor_if.sv
// Bus between a counter-driven producer and cnt_seq_monitor.
// master: drives the samples, bounds and clear, and receives the status.
// slave : the monitor side.
//   en, cnt_in, min, max, clr_err  producer -> monitor
//   locked, dir_up, hold           level status
//   wrap_pulse, flip_pulse, step_err  one-cycle event pulses
//   cfg_err                        bounds inverted (min > max)
//   err_cnt, lap_cnt               event counters
interface cnt_seq_monitor_if #(
  parameter int unsigned W    = 4,
  parameter int unsigned ERRW = 8
);
  logic            en;
  logic [W-1:0]    cnt_in;
  logic [W-1:0]    min;
  logic [W-1:0]    max;
  logic            clr_err;
  logic            locked;
  logic            dir_up;
  logic            hold;
  logic            wrap_pulse;
  logic            flip_pulse;
  logic            step_err;
  logic            cfg_err;
  logic [ERRW-1:0] err_cnt;
  logic [ERRW-1:0] lap_cnt;

  modport master (
    output en, cnt_in, min, max, clr_err,
    input  locked, dir_up, hold, wrap_pulse, flip_pulse, step_err, cfg_err,
           err_cnt, lap_cnt
  );

  modport slave (
    input  en, cnt_in, min, max, clr_err,
    output locked, dir_up, hold, wrap_pulse, flip_pulse, step_err, cfg_err,
           err_cnt, lap_cnt
  );
endinterface

// File: rtl/cnt_seq_monitor.sv
// Run-time checker for a bounded wrapping up/down counter.
// Watches one sample per enabled cycle, infers direction, and reports wraps,
// reversals, holds and illegal steps. All status is registered (1-cycle latency).
// Ports: clk, rst (sync, active-high), bus (slave modport of cnt_seq_monitor_if).
module cnt_seq_monitor #(
  parameter int unsigned W    = 4,
  parameter int unsigned ERRW = 8
) (
  input  logic               clk,
  input  logic               rst,
  cnt_seq_monitor_if.slave   bus
);

  localparam int unsigned WE = W + 1;

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  typedef enum logic [2:0] {CL_OOR, CL_HOLD, CL_UPW, CL_DNW, CL_UP, CL_DN, CL_ILL} cls_t;

  state_t          state_q, state_d;
  logic [W-1:0]    prev_q, prev_d;
  logic            locked_q, locked_d;
  logic            dir_up_q, dir_up_d;
  logic            hold_q, hold_d;
  logic            wrap_q, wrap_d;
  logic            flip_q, flip_d;
  logic            serr_q, serr_d;
  logic            cfg_q;
  logic [ERRW-1:0] err_q, err_d;
  logic [ERRW-1:0] lap_q, lap_d;

  logic            cfg_bad;
  logic            oor;
  logic [W:0]      c_x, p_inc, p_dec;
  cls_t            cls;
  logic            is_up, is_dn, is_wrap;

  // Sample classification; +/-1 done one bit wider so the bounds never alias.
  always_comb begin
    cfg_bad = bus.min > bus.max;
    oor     = (bus.cnt_in < bus.min) || (bus.cnt_in > bus.max);
    c_x     = {1'b0, bus.cnt_in};
    p_inc   = {1'b0, prev_q} + WE'(1);
    p_dec   = {1'b0, prev_q} - WE'(1);
    cls     = CL_ILL;
    if (oor)                                             cls = CL_OOR;
    else if (bus.cnt_in == prev_q)                       cls = CL_HOLD;
    else if (prev_q == bus.max && bus.cnt_in == bus.min) cls = CL_UPW;
    else if (prev_q == bus.min && bus.cnt_in == bus.max) cls = CL_DNW;
    else if (c_x == p_inc && prev_q != bus.max)          cls = CL_UP;
    else if (c_x == p_dec && prev_q != bus.min)          cls = CL_DN;
    is_up   = (cls == CL_UP) || (cls == CL_UPW);
    is_dn   = (cls == CL_DN) || (cls == CL_DNW);
    is_wrap = (cls == CL_UPW) || (cls == CL_DNW);
  end

  // Next-state and next-status logic.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    locked_d = locked_q;
    dir_up_d = dir_up_q;
    hold_d   = hold_q;
    wrap_d   = 1'b0;
    flip_d   = 1'b0;
    serr_d   = 1'b0;

    if (cfg_bad || !bus.en) begin
      // Bad bounds or a sampling gap: forget history, keep counters.
      state_d  = IDLE;
      locked_d = 1'b0;
      hold_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          locked_d = 1'b0;
          hold_d   = 1'b0;
          if (oor) begin
            serr_d = 1'b1;
          end else begin
            prev_d  = bus.cnt_in;
            state_d = ACQ;
          end
        end
        ACQ, TRACK: begin
          prev_d = bus.cnt_in;
          hold_d = (cls == CL_HOLD);
          wrap_d = is_wrap;
          if (is_up || is_dn) begin
            flip_d   = (state_q == TRACK) && (dir_up_q != is_up);
            dir_up_d = is_up;
            locked_d = 1'b1;
            state_d  = TRACK;
          end else if (cls != CL_HOLD) begin
            serr_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = (cls == CL_OOR) ? IDLE : ACQ;
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
          hold_d   = 1'b0;
        end
      endcase
    end

    // Clear wins over a coincident event.
    err_d = err_q;
    lap_d = lap_q;
    if (bus.clr_err) begin
      err_d = '0;
      lap_d = '0;
    end else begin
      if (serr_d && err_q != '1) err_d = err_q + ERRW'(1);
      if (wrap_d)                lap_d = lap_q + ERRW'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      locked_q <= 1'b0;
      dir_up_q <= 1'b1;
      hold_q   <= 1'b0;
      wrap_q   <= 1'b0;
      flip_q   <= 1'b0;
      serr_q   <= 1'b0;
      cfg_q    <= 1'b0;
      err_q    <= '0;
      lap_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      locked_q <= locked_d;
      dir_up_q <= dir_up_d;
      hold_q   <= hold_d;
      wrap_q   <= wrap_d;
      flip_q   <= flip_d;
      serr_q   <= serr_d;
      cfg_q    <= cfg_bad;
      err_q    <= err_d;
      lap_q    <= lap_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.dir_up     = dir_up_q;
  assign bus.hold       = hold_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.flip_pulse = flip_q;
  assign bus.step_err   = serr_q;
  assign bus.cfg_err    = cfg_q;
  assign bus.err_cnt    = err_q;
  assign bus.lap_cnt    = lap_q;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Self-checking bench for cnt_seq_monitor: directed scenarios plus a
// randomized run checked against a behavioural model of the counter rules.
module tb_cnt_seq_monitor;
  localparam int unsigned W    = 4;
  localparam int unsigned ERRW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnt_seq_monitor_if #(.W(W), .ERRW(ERRW)) bus ();
  cnt_seq_monitor #(.W(W), .ERRW(ERRW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit m_pv, m_locked, m_dir, m_hold, m_wrap, m_flip, m_serr, m_cfg;
  int m_prev, m_err, m_lap;

  task automatic model_update();
    int lo, hi, c;
    bit up, dn, wr;
    lo = int'(bus.min); hi = int'(bus.max); c = int'(bus.cnt_in);
    m_wrap = 0; m_flip = 0; m_serr = 0;
    if (rst) begin
      m_pv = 0; m_prev = 0; m_locked = 0; m_dir = 1; m_hold = 0;
      m_cfg = 0; m_err = 0; m_lap = 0;
      return;
    end
    m_cfg = (lo > hi);
    if (lo > hi || !bus.en) begin
      m_pv = 0; m_locked = 0; m_hold = 0;
    end else if (c < lo || c > hi) begin
      m_serr = 1; m_pv = 0; m_locked = 0; m_hold = 0;
    end else if (!m_pv) begin
      m_pv = 1; m_prev = c; m_hold = 0;
    end else begin
      up = 0; dn = 0; wr = 0;
      if (c == m_prev) m_hold = 1;
      else begin
        m_hold = 0;
        if (m_prev == hi && c == lo)      begin up = 1; wr = 1; end
        else if (m_prev == lo && c == hi) begin dn = 1; wr = 1; end
        else if (c - m_prev == 1)         up = 1;
        else if (m_prev - c == 1)         dn = 1;
        if (up || dn) begin
          if (m_locked && m_dir != up) m_flip = 1;
          m_dir = up; m_locked = 1; m_wrap = wr;
        end else begin
          m_serr = 1; m_locked = 0;
        end
      end
      m_prev = c;
    end
    if (bus.clr_err) begin
      m_err = 0; m_lap = 0;
    end else begin
      if (m_serr && m_err < 255) m_err++;
      if (m_wrap) m_lap = (m_lap + 1) % 256;
    end
  endtask

  // Drive one sample, clock it in, and leave outputs settled for checking.
  task automatic cycle(input bit r, input bit e, input int c, input bit clr);
    rst = r; bus.en = e; bus.cnt_in = W'(c); bus.clr_err = clr;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_bounds(input int lo, input int hi);
    bus.min = W'(lo); bus.max = W'(hi);
  endtask

  task automatic test_reset();
    set_bounds(3, 9);
    cycle(1, 0, 0, 0);
    n_cmp++;
    if ({bus.locked, bus.dir_up, bus.hold, bus.wrap_pulse, bus.flip_pulse, bus.step_err, bus.cfg_err} !== 7'b0100000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0100000",
        {bus.locked, bus.dir_up, bus.hold, bus.wrap_pulse, bus.flip_pulse, bus.step_err, bus.cfg_err});
    end
    n_cmp++;
    if (bus.err_cnt !== ERRW'(0) || bus.lap_cnt !== ERRW'(0)) begin
      n_bad++; $display("FAIL reset_cnt: got err=%0d lap=%0d want 0 0", bus.err_cnt, bus.lap_cnt);
    end
  endtask

  task automatic test_up_wrap();
    int seq[9] = '{3, 4, 5, 6, 7, 8, 9, 3, 4};
    int wraps = 0, wrap_at = -1, errs = 0;
    set_bounds(3, 9);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, seq[i], 0);
      if (bus.wrap_pulse) begin wraps++; wrap_at = i; end
      if (bus.step_err) errs++;
      if (i == 1) begin
        n_cmp++;
        if (bus.locked !== 1'b1 || bus.dir_up !== 1'b1) begin
          n_bad++; $display("FAIL up_lock: got locked=%b dir_up=%b want 1 1", bus.locked, bus.dir_up);
        end
      end
    end
    n_cmp++;
    if (wraps != 1 || wrap_at != 7) begin
      n_bad++; $display("FAIL up_wrap: got %0d wraps at %0d want 1 at 7", wraps, wrap_at);
    end
    n_cmp++;
    if (errs != 0 || bus.lap_cnt !== ERRW'(1)) begin
      n_bad++; $display("FAIL up_lap: got errs=%0d lap=%0d want 0 1", errs, bus.lap_cnt);
    end
  endtask

  task automatic test_down_wrap();
    int seq[8] = '{9, 8, 7, 6, 5, 4, 3, 9};
    int wraps = 0, wrap_at = -1;
    set_bounds(3, 9);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, seq[i], 0);
      if (bus.wrap_pulse) begin wraps++; wrap_at = i; end
    end
    n_cmp++;
    if (wraps != 1 || wrap_at != 7) begin
      n_bad++; $display("FAIL dn_wrap: got %0d wraps at %0d want 1 at 7", wraps, wrap_at);
    end
    n_cmp++;
    if (bus.dir_up !== 1'b0 || bus.locked !== 1'b1 || bus.lap_cnt !== ERRW'(1)) begin
      n_bad++; $display("FAIL dn_state: got dir_up=%b locked=%b lap=%0d want 0 1 1", bus.dir_up, bus.locked, bus.lap_cnt);
    end
  endtask

  task automatic test_fault();
    set_bounds(3, 9);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 5, 0);
    cycle(0, 1, 6, 0);
    cycle(0, 1, 8, 0);
    n_cmp++;
    if (bus.step_err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== ERRW'(1)) begin
      n_bad++; $display("FAIL ill_step: got serr=%b locked=%b err=%0d want 1 0 1", bus.step_err, bus.locked, bus.err_cnt);
    end
    cycle(0, 1, 9, 0);
    n_cmp++;
    if (bus.step_err !== 1'b0 || bus.locked !== 1'b1 || bus.dir_up !== 1'b1) begin
      n_bad++; $display("FAIL relock: got serr=%b locked=%b dir_up=%b want 0 1 1", bus.step_err, bus.locked, bus.dir_up);
    end
    cycle(0, 1, 12, 0);
    n_cmp++;
    if (bus.step_err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== ERRW'(2)) begin
      n_bad++; $display("FAIL oor: got serr=%b locked=%b err=%0d want 1 0 2", bus.step_err, bus.locked, bus.err_cnt);
    end
    // From IDLE a fresh sample is captured without judging it against 12.
    cycle(0, 1, 4, 0);
    cycle(0, 1, 5, 0);
    n_cmp++;
    if (bus.step_err !== 1'b0 || bus.locked !== 1'b1 || bus.err_cnt !== ERRW'(2)) begin
      n_bad++; $display("FAIL oor_idle: got serr=%b locked=%b err=%0d want 0 1 2", bus.step_err, bus.locked, bus.err_cnt);
    end
  endtask

  task automatic test_reversal_hold();
    int seq[5] = '{4, 5, 6, 5, 4};
    int flips = 0, flip_at = -1;
    set_bounds(3, 9);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, seq[i], 0);
      if (bus.flip_pulse) begin flips++; flip_at = i; end
    end
    n_cmp++;
    if (flips != 1 || flip_at != 3 || bus.dir_up !== 1'b0 || bus.locked !== 1'b1) begin
      n_bad++; $display("FAIL reversal: got %0d flips at %0d dir_up=%b locked=%b want 1 at 3 0 1",
        flips, flip_at, bus.dir_up, bus.locked);
    end
    cycle(0, 1, 5, 0);
    cycle(0, 1, 6, 0);
    n_cmp++;
    if (bus.hold !== 1'b0 || bus.dir_up !== 1'b1) begin
      n_bad++; $display("FAIL pre_hold: got hold=%b dir_up=%b want 0 1", bus.hold, bus.dir_up);
    end
    cycle(0, 1, 6, 0);
    cycle(0, 1, 6, 0);
    n_cmp++;
    if (bus.hold !== 1'b1 || bus.locked !== 1'b1 || bus.step_err !== 1'b0) begin
      n_bad++; $display("FAIL hold: got hold=%b locked=%b serr=%b want 1 1 0", bus.hold, bus.locked, bus.step_err);
    end
    cycle(0, 1, 7, 0);
    n_cmp++;
    if (bus.hold !== 1'b0 || bus.locked !== 1'b1) begin
      n_bad++; $display("FAIL unhold: got hold=%b locked=%b want 0 1", bus.hold, bus.locked);
    end
  endtask

  task automatic test_cfg();
    set_bounds(10, 2);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, int'($urandom_range(0, 15)), 0);
      n_cmp++;
      if (bus.cfg_err !== 1'b1 || bus.wrap_pulse !== 1'b0 || bus.flip_pulse !== 1'b0 ||
          bus.step_err !== 1'b0 || bus.locked !== 1'b0) begin
        n_bad++; $display("FAIL cfg_quiet[%0d]: got cfg=%b wrap=%b flip=%b serr=%b locked=%b want 1 0 0 0 0",
          i, bus.cfg_err, bus.wrap_pulse, bus.flip_pulse, bus.step_err, bus.locked);
      end
    end
    set_bounds(0, 15);
    cycle(0, 1, 15, 0);
    n_cmp++;
    if (bus.cfg_err !== 1'b0 || bus.step_err !== 1'b0) begin
      n_bad++; $display("FAIL cfg_restore: got cfg=%b serr=%b want 0 0", bus.cfg_err, bus.step_err);
    end
    cycle(0, 1, 0, 0);
    n_cmp++;
    if (bus.wrap_pulse !== 1'b1 || bus.locked !== 1'b1 || bus.dir_up !== 1'b1) begin
      n_bad++; $display("FAIL full_wrap: got wrap=%b locked=%b dir_up=%b want 1 1 1", bus.wrap_pulse, bus.locked, bus.dir_up);
    end
  endtask

  task automatic test_saturation();
    set_bounds(0, 15);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    for (int i = 1; i <= 260; i++) begin
      cycle(0, 1, (i % 2 == 1) ? 8 : 0, 0);
      if (i == 100) begin
        n_cmp++;
        if (bus.err_cnt !== ERRW'(100)) begin
          n_bad++; $display("FAIL sat_mid: got %0d want 100", bus.err_cnt);
        end
      end
    end
    n_cmp++;
    if (bus.err_cnt !== ERRW'(255) || bus.step_err !== 1'b1) begin
      n_bad++; $display("FAIL sat_end: got err=%0d serr=%b want 255 1", bus.err_cnt, bus.step_err);
    end
  endtask

  task automatic test_control();
    set_bounds(0, 15);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 2, 0);
    cycle(0, 1, 1, 0);
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.dir_up !== 1'b0) begin
      n_bad++; $display("FAIL ctl_pre: got locked=%b dir_up=%b want 1 0", bus.locked, bus.dir_up);
    end
    cycle(1, 1, 0, 0);
    n_cmp++;
    if ({bus.locked, bus.dir_up, bus.hold, bus.wrap_pulse, bus.flip_pulse, bus.step_err,
         bus.cfg_err, bus.err_cnt, bus.lap_cnt} !== {7'b0100000, 16'h0}) begin
      n_bad++; $display("FAIL mid_reset: got locked=%b dir_up=%b err=%0d lap=%0d want 0 1 0 0",
        bus.locked, bus.dir_up, bus.err_cnt, bus.lap_cnt);
    end
    cycle(0, 1, 14, 0);
    cycle(0, 1, 15, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 5, 0);
    cycle(0, 1, 6, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 7, 0);
      n_cmp++;
      if (bus.locked !== 1'b0 || bus.hold !== 1'b0 || bus.err_cnt !== ERRW'(1) || bus.lap_cnt !== ERRW'(1)) begin
        n_bad++; $display("FAIL en_drop[%0d]: got locked=%b hold=%b err=%0d lap=%0d want 0 0 1 1",
          i, bus.locked, bus.hold, bus.err_cnt, bus.lap_cnt);
      end
    end
    cycle(0, 1, 3, 0);
    cycle(0, 1, 4, 0);
    cycle(0, 1, 9, 1);
    n_cmp++;
    if (bus.step_err !== 1'b1 || bus.err_cnt !== ERRW'(0) || bus.lap_cnt !== ERRW'(0)) begin
      n_bad++; $display("FAIL clr_wins: got serr=%b err=%0d lap=%0d want 1 0 0", bus.step_err, bus.err_cnt, bus.lap_cnt);
    end
  endtask

  task automatic test_random();
    int lo = 0, hi = 15, g = 0, r;
    bit d = 1, e, clr, rr;
    logic [22:0] act, exp;
    set_bounds(lo, hi);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) begin lo = int'($urandom_range(8, 15)); hi = int'($urandom_range(0, 7)); end
        else if (r == 1) begin lo = int'($urandom_range(0, 15)); hi = lo; end
        else begin lo = int'($urandom_range(0, 12)); hi = int'($urandom_range(lo + 1, 15)); end
        set_bounds(lo, hi);
      end
      r = int'($urandom_range(0, 99));
      e = 1; clr = 0; rr = 0;
      if (r >= 55 && r < 65) d = !d;
      if (r < 65 || (r >= 92 && r < 97)) begin
        if (lo > hi)  g = int'($urandom_range(0, 15));
        else if (d)   g = (g >= hi) ? lo : g + 1;
        else          g = (g <= lo) ? hi : g - 1;
      end else if (r < 75) begin
        g = g;
      end else if (r < 85) begin
        g = int'($urandom_range(0, 15));
      end else if (r < 92) begin
        e = 0;
      end else if (r >= 99) begin
        rr = 1;
      end
      if (r >= 92 && r < 97) clr = 1;
      cycle(rr, e, g, clr);
      act = {bus.locked, bus.dir_up, bus.hold, bus.wrap_pulse, bus.flip_pulse, bus.step_err,
             bus.cfg_err, bus.err_cnt, bus.lap_cnt};
      exp = {m_locked, m_dir, m_hold, m_wrap, m_flip, m_serr, m_cfg, ERRW'(m_err), ERRW'(m_lap)};
      n_cmp++;
      if (act !== exp) begin
        n_bad++; $display("FAIL rand[%0d]: got %h want %h (min=%0d max=%0d cnt_in=%0d)", i, act, exp, lo, hi, g);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.cnt_in = '0; bus.clr_err = 1'b0;
    bus.min = W'(3); bus.max = W'(9);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_fault();
    test_reversal_hold();
    test_cfg();
    test_saturation();
    test_control();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
